// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared sizes and ALU op codes for the reservation station and decoder.
package reservation_station_pkg;
  localparam int RS_SIZE = 8;
  localparam int RS_BITS = $clog2(RS_SIZE);
  localparam int ROB_BITS = 4;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU, ALU_JALR
  } alu_op_e;
endpackage

// File: rtl/reservation_station_alu.sv
// alu: combinational integer ALU; branches yield 1 when taken, jalr yields the aligned target.
module alu
  import reservation_station_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_BEQ:  result = {31'b0, a == b};
      ALU_BNE:  result = {31'b0, a != b};
      ALU_BLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_BGE:  result = {31'b0, $signed(a) >= $signed(b)};
      ALU_BLTU: result = {31'b0, a < b};
      ALU_BGEU: result = {31'b0, a >= b};
      ALU_JALR: result = (a + imm) & ~32'd1;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: ALU issue queue that snoops result broadcasts and executes one ready op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int BITS = ROB_BITS
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            RoB_clear,
  input  logic            issue_valid,
  input  logic [4:0]      issue_op,
  input  logic [BITS-1:0] issue_rob_id,
  input  logic [31:0]     issue_vj,
  input  logic [31:0]     issue_vk,
  input  logic            issue_qj_busy,
  input  logic            issue_qk_busy,
  input  logic [BITS-1:0] issue_qj,
  input  logic [BITS-1:0] issue_qk,
  input  logic [31:0]     issue_imm,
  input  logic            RoB_rdy_RS,
  input  logic [BITS-1:0] RoB_id_RS,
  input  logic [31:0]     RoB_value_RS,
  input  logic            RoB_rdy_LSB,
  input  logic [BITS-1:0] RoB_id_LSB,
  input  logic [31:0]     RoB_value_LSB,
  output logic            full,
  output logic            RS_finish_rdy,
  output logic [BITS-1:0] RS_finish_id,
  output logic [31:0]     RS_finish_value
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
  logic [4:0]      op_q [RS_SIZE], op_d [RS_SIZE];
  logic [31:0]     vj_q [RS_SIZE], vj_d [RS_SIZE], vk_q [RS_SIZE], vk_d [RS_SIZE];
  logic [31:0]     imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [BITS-1:0] qj_q [RS_SIZE], qj_d [RS_SIZE], qk_q [RS_SIZE], qk_d [RS_SIZE];
  logic [BITS-1:0] rob_q [RS_SIZE], rob_d [RS_SIZE];
  logic            finish_rdy_q, finish_rdy_d;
  logic [BITS-1:0] finish_id_q, finish_id_d;
  logic [31:0]     finish_value_q, finish_value_d;
  logic            free_ok, sel_ok;
  logic [IW-1:0]   free_idx, sel_idx;
  logic [31:0]     alu_res;
  // Returns {still_pending, value}; the RS broadcast wins over LSB.
  function automatic logic [32:0] snoop(input logic qb, input logic [BITS-1:0] q, input logic [31:0] v);
    snoop = !qb ? {1'b0, v} :
            (RoB_rdy_RS && RoB_id_RS == q) ? {1'b0, RoB_value_RS} :
            (RoB_rdy_LSB && RoB_id_LSB == q) ? {1'b0, RoB_value_LSB} : {1'b1, v};
  endfunction
  alu u_alu (.op(op_q[sel_idx]), .a(vj_q[sel_idx]), .b(vk_q[sel_idx]), .imm(imm_q[sel_idx]), .result(alu_res));
  always_comb begin
    busy_d = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    op_d = op_q;
    vj_d = vj_q;
    vk_d = vk_q;
    imm_d = imm_q;
    qj_d = qj_q;
    qk_d = qk_q;
    rob_d = rob_q;
    free_ok = 1'b0;
    free_idx = '0;
    sel_ok = 1'b0;
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_ok = 1'b1;
        free_idx = IW'(i);
      end
      if (busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i]) begin
        sel_ok = 1'b1;
        sel_idx = IW'(i);
      end
      {qj_busy_d[i], vj_d[i]} = snoop(qj_busy_q[i], qj_q[i], vj_q[i]);
      {qk_busy_d[i], vk_d[i]} = snoop(qk_busy_q[i], qk_q[i], vk_q[i]);
    end
    if (sel_ok) busy_d[sel_idx] = 1'b0;
    // Free slot comes from registered busy, so a slot freed this cycle is reusable only next cycle.
    if (issue_valid && free_ok) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx] = issue_op;
      imm_d[free_idx] = issue_imm;
      qj_d[free_idx] = issue_qj;
      qk_d[free_idx] = issue_qk;
      rob_d[free_idx] = issue_rob_id;
      {qj_busy_d[free_idx], vj_d[free_idx]} = snoop(issue_qj_busy, issue_qj, issue_vj);
      {qk_busy_d[free_idx], vk_d[free_idx]} = snoop(issue_qk_busy, issue_qk, issue_vk);
    end
    finish_rdy_d = sel_ok;
    finish_id_d = sel_ok ? rob_q[sel_idx] : finish_id_q;
    finish_value_d = sel_ok ? alu_res : finish_value_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in || RoB_clear) begin
      busy_q <= '0;
      finish_rdy_q <= 1'b0;
      finish_id_q <= '0;
      finish_value_q <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      op_q <= op_d;
      vj_q <= vj_d;
      vk_q <= vk_d;
      imm_q <= imm_d;
      qj_q <= qj_d;
      qk_q <= qk_d;
      rob_q <= rob_d;
      finish_rdy_q <= finish_rdy_d;
      finish_id_q <= finish_id_d;
      finish_value_q <= finish_value_d;
    end
  end
  assign full = &busy_q;
  assign RS_finish_rdy = finish_rdy_q;
  assign RS_finish_id = finish_id_q;
  assign RS_finish_value = finish_value_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed stimulus checked every cycle against a slot-level behavioural model.
module tb_reservation_station;
  import reservation_station_pkg::*;
  logic clk = 0, rst_in = 1, rdy_in = 1, RoB_clear = 0;
  logic issue_valid = 0, issue_qj_busy = 0, issue_qk_busy = 0;
  logic [4:0] issue_op = 0;
  logic [3:0] issue_rob_id = 0, issue_qj = 0, issue_qk = 0;
  logic [31:0] issue_vj = 0, issue_vk = 0, issue_imm = 0;
  logic RoB_rdy_RS = 0, RoB_rdy_LSB = 0;
  logic [3:0] RoB_id_RS = 0, RoB_id_LSB = 0;
  logic [31:0] RoB_value_RS = 0, RoB_value_LSB = 0;
  logic full, RS_finish_rdy;
  logic [3:0] RS_finish_id;
  logic [31:0] RS_finish_value;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  reservation_station #(.RS_SIZE(8), .BITS(4)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_busy(issue_qj_busy),
    .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .RoB_rdy_RS(RoB_rdy_RS), .RoB_id_RS(RoB_id_RS),
    .RoB_value_RS(RoB_value_RS), .RoB_rdy_LSB(RoB_rdy_LSB), .RoB_id_LSB(RoB_id_LSB),
    .RoB_value_LSB(RoB_value_LSB), .full(full), .RS_finish_rdy(RS_finish_rdy),
    .RS_finish_id(RS_finish_id), .RS_finish_value(RS_finish_value));
  always #5 clk = ~clk;
  // Model: slots with "operand known" flags; expected outputs after each edge.
  bit m_busy [8], m_rj [8], m_rk [8];
  logic [4:0] m_op [8];
  logic [3:0] m_qj [8], m_qk [8], m_rob [8];
  logic [31:0] m_vj [8], m_vk [8], m_imm [8];
  bit e_rdy = 0;
  logic [3:0] e_id = 0;
  logic [31:0] e_val = 0;
  function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a, b, imm);
    logic [31:0] r;
    r = 0;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd6: r = (a < b) ? 1 : 0;
      5'd7: r = a << b[4:0];
      5'd8: r = a >> b[4:0];
      5'd9: r = $signed(a) >>> b[4:0];
      5'd10: r = (a == b) ? 1 : 0;
      5'd11: r = (a != b) ? 1 : 0;
      5'd12: r = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd13: r = ($signed(a) >= $signed(b)) ? 1 : 0;
      5'd14: r = (a < b) ? 1 : 0;
      5'd15: r = (a >= b) ? 1 : 0;
      5'd16: r = (a + imm) & 32'hFFFF_FFFE;
      default: r = 0;
    endcase
    return r;
  endfunction
  task automatic grab(input bit known, input logic [3:0] tag, input logic [31:0] v,
                      output bit known_o, output logic [31:0] v_o);
    known_o = 1;
    v_o = v;
    if (!known) begin
      if (RoB_rdy_RS && RoB_id_RS == tag) v_o = RoB_value_RS;
      else if (RoB_rdy_LSB && RoB_id_LSB == tag) v_o = RoB_value_LSB;
      else known_o = 0;
    end
  endtask
  always @(posedge clk) begin
    if (rst_in || RoB_clear) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      e_rdy = 0; e_id = 0; e_val = 0;
    end else if (rdy_in) begin
      int s, f;
      s = -1; f = -1;
      for (int i = 0; i < 8; i++) begin
        if (s < 0 && m_busy[i] && m_rj[i] && m_rk[i]) s = i;
        if (f < 0 && !m_busy[i]) f = i;
      end
      e_rdy = (s >= 0);
      if (s >= 0) begin
        e_id = m_rob[s];
        e_val = model_alu(m_op[s], m_vj[s], m_vk[s], m_imm[s]);
      end
      for (int i = 0; i < 8; i++) if (m_busy[i]) begin
        grab(m_rj[i], m_qj[i], m_vj[i], m_rj[i], m_vj[i]);
        grab(m_rk[i], m_qk[i], m_vk[i], m_rk[i], m_vk[i]);
      end
      if (s >= 0) m_busy[s] = 0;
      if (issue_valid && f >= 0) begin
        m_busy[f] = 1; m_op[f] = issue_op; m_imm[f] = issue_imm; m_rob[f] = issue_rob_id;
        m_qj[f] = issue_qj; m_qk[f] = issue_qk;
        grab(!issue_qj_busy, issue_qj, issue_vj, m_rj[f], m_vj[f]);
        grab(!issue_qk_busy, issue_qk, issue_vk, m_rk[f], m_vk[f]);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    bit mf;
    mf = 1;
    for (int i = 0; i < 8; i++) mf = mf & m_busy[i];
    chk("model_full", {31'b0, full}, {31'b0, mf});
    chk("model_rdy", {31'b0, RS_finish_rdy}, {31'b0, e_rdy});
    if (e_rdy) begin
      chk("model_id", {28'b0, RS_finish_id}, {28'b0, e_id});
      chk("model_value", RS_finish_value, e_val);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    issue_valid = 0; RoB_rdy_RS = 0; RoB_rdy_LSB = 0;
  endtask
  task automatic iss(input logic [4:0] op, input logic [3:0] rob, input logic [31:0] vj, vk,
                     input bit qjb, input logic [3:0] qj, input bit qkb, input logic [3:0] qk,
                     input logic [31:0] imm);
    issue_valid = 1; issue_op = op; issue_rob_id = rob; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk; issue_imm = imm;
  endtask
  task automatic lit(input string name, input logic rdy, input logic [3:0] id, input logic [31:0] val);
    chk({name, "_rdy"}, {31'b0, RS_finish_rdy}, {31'b0, rdy});
    if (rdy) begin
      chk({name, "_id"}, {28'b0, RS_finish_id}, {28'b0, id});
      chk({name, "_val"}, RS_finish_value, val);
    end
  endtask
  initial begin
    step(); step();
    rst_in = 0;
    chk_en = 1;
    lit("reset", 0, 0, 0);
    chk("reset_id", {28'b0, RS_finish_id}, 0);
    chk("reset_val", RS_finish_value, 0);
    chk("reset_full", {31'b0, full}, 0);
    iss(ALU_ADD, 3, 5, 7, 0, 0, 0, 0, 0); step();
    lit("add_early", 0, 0, 0);
    step(); lit("add", 1, 3, 12);
    step(); lit("add_after", 0, 0, 0);
    iss(ALU_SUB, 5, 0, 1, 1, 2, 0, 0, 0); step(); step();
    RoB_rdy_LSB = 1; RoB_id_LSB = 2; RoB_value_LSB = 100; step();
    lit("sub_wait", 0, 0, 0);
    step(); lit("sub", 1, 5, 99);
    iss(ALU_SLL, 6, 3, 0, 0, 0, 1, 4, 0);
    RoB_rdy_RS = 1; RoB_id_RS = 4; RoB_value_RS = 8; step();
    step(); lit("sll_capture", 1, 6, 768);
    step();
    for (int i = 0; i < 8; i++) begin
      iss(ALU_ADD, 4'(i), 0, i, 1, (i == 0) ? 4'd9 : 4'd10, 0, 0, 0); step();
    end
    chk("fill_full", {31'b0, full}, 1);
    RoB_rdy_RS = 1; RoB_id_RS = 9; RoB_value_RS = 100; step();
    chk("wake_full", {31'b0, full}, 1);
    step();
    chk("freed_full", {31'b0, full}, 0);
    lit("wake0", 1, 0, 100);
    RoB_rdy_LSB = 1; RoB_id_LSB = 10; RoB_value_LSB = 1; step();
    for (int i = 0; i < 8; i++) step();
    iss(ALU_BLTU, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); step();
    iss(ALU_JALR, 2, 32'h1001, 0, 0, 0, 0, 0, 4); step();
    lit("bltu", 1, 1, 1);
    step(); lit("jalr", 1, 2, 32'h1004);
    iss(ALU_ADD, 9, 2, 2, 0, 0, 0, 0, 0); step();
    rdy_in = 0; step(); step();
    lit("hold", 0, 0, 0);
    rdy_in = 1; step(); lit("hold_release", 1, 9, 4);
    step();
    for (int i = 0; i < 3; i++) begin
      iss(ALU_OR, 4'(10 + i), 0, 1, 1, 12, 0, 0, 0); step();
    end
    iss(ALU_ADD, 13, 1, 1, 0, 0, 0, 0, 0); step();
    iss(ALU_ADD, 14, 2, 2, 0, 0, 0, 0, 0); step();
    lit("pre_clear", 1, 13, 2);
    RoB_clear = 1;
    iss(ALU_ADD, 15, 3, 3, 0, 0, 0, 0, 0);
    RoB_rdy_LSB = 1; RoB_id_LSB = 12; RoB_value_LSB = 7; step();
    RoB_clear = 0;
    lit("clear", 0, 0, 0);
    chk("clear_full", {31'b0, full}, 0);
    for (int i = 0; i < 4; i++) begin
      RoB_rdy_LSB = 1; RoB_id_LSB = 12; RoB_value_LSB = 7; step();
      lit("no_stale", 0, 0, 0);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
